// File: rtl/pipe_id_ex.sv
// ID/EX pipeline register for the pipelined OTTER core, with EX-stage operand
// forwarding from MEM/WB and load-use hazard detection against the ID stage.
module pipe_id_ex #(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              stall,
   input  logic              flush,
   input  logic              id_valid,
   input  logic [XLEN-1:0]   id_pc,
   input  logic [XLEN-1:0]   id_rs1_data,
   input  logic [XLEN-1:0]   id_rs2_data,
   input  logic [XLEN-1:0]   id_imm,
   input  logic [REG_AW-1:0] id_rs1_addr,
   input  logic [REG_AW-1:0] id_rs2_addr,
   input  logic [REG_AW-1:0] id_rd_addr,
   input  logic [3:0]        id_alu_fun,
   input  logic              id_srcA_sel,
   input  logic              id_srcB_sel,
   input  logic              id_reg_write,
   input  logic              id_mem_read,
   input  logic              id_mem_write,
   input  logic [REG_AW-1:0] mem_rd_addr,
   input  logic              mem_reg_write,
   input  logic [XLEN-1:0]   mem_result,
   input  logic [REG_AW-1:0] wb_rd_addr,
   input  logic              wb_reg_write,
   input  logic [XLEN-1:0]   wb_result,
   output logic              ex_valid,
   output logic [XLEN-1:0]   ex_pc,
   output logic [XLEN-1:0]   ex_srcA,
   output logic [XLEN-1:0]   ex_srcB,
   output logic [3:0]        ex_alu_fun,
   output logic [XLEN-1:0]   ex_store_data,
   output logic [REG_AW-1:0] ex_rd_addr,
   output logic              ex_reg_write,
   output logic              ex_mem_read,
   output logic              ex_mem_write,
   output logic              hazard_stall
);

   typedef struct packed {
      logic              valid;
      logic [XLEN-1:0]   pc;
      logic [XLEN-1:0]   rs1Data;
      logic [XLEN-1:0]   rs2Data;
      logic [XLEN-1:0]   imm;
      logic [REG_AW-1:0] rs1Addr;
      logic [REG_AW-1:0] rs2Addr;
      logic [REG_AW-1:0] rdAddr;
      logic [3:0]        aluFun;
      logic              srcASel;
      logic              srcBSel;
      logic              regWrite;
      logic              memRead;
      logic              memWrite;
   } exFields_t;

   exFields_t ex_q;
   exFields_t ex_d;
   exFields_t idFields;

   logic              memHit1;
   logic              memHit2;
   logic              wbHit1;
   logic              wbHit2;
   logic [XLEN-1:0]   fwd1;
   logic [XLEN-1:0]   fwd2;

   // Control bits of an invalid ID slot must never reach EX as live writes.
   always_comb begin
      idFields          = '0;
      idFields.valid    = id_valid;
      idFields.pc       = id_pc;
      idFields.rs1Data  = id_rs1_data;
      idFields.rs2Data  = id_rs2_data;
      idFields.imm      = id_imm;
      idFields.rs1Addr  = id_rs1_addr;
      idFields.rs2Addr  = id_rs2_addr;
      idFields.rdAddr   = id_rd_addr;
      idFields.aluFun   = id_alu_fun;
      idFields.srcASel  = id_srcA_sel;
      idFields.srcBSel  = id_srcB_sel;
      idFields.regWrite = id_reg_write & id_valid;
      idFields.memRead  = id_mem_read & id_valid;
      idFields.memWrite = id_mem_write & id_valid;
   end

   // Conservative: rs2 is compared even when the ID instruction does not use it.
   assign hazard_stall = ex_q.valid && ex_q.memRead && (ex_q.rdAddr != '0) && id_valid &&
                         ((ex_q.rdAddr == id_rs1_addr) || (ex_q.rdAddr == id_rs2_addr));

   // flush beats stall; stall beats the load-use bubble so EX is never lost.
   always_comb begin
      ex_d = ex_q;
      if (flush) begin
         ex_d = '0;
      end else if (stall) begin
         ex_d = ex_q;
      end else if (hazard_stall) begin
         ex_d = '0;
      end else begin
         ex_d = idFields;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         ex_q <= '0;
      end else begin
         ex_q <= ex_d;
      end
   end

   // MEM is the younger producer, so it wins over WB; x0 is never forwarded.
   assign memHit1 = mem_reg_write && (mem_rd_addr != '0) && (mem_rd_addr == ex_q.rs1Addr);
   assign memHit2 = mem_reg_write && (mem_rd_addr != '0) && (mem_rd_addr == ex_q.rs2Addr);
   assign wbHit1  = wb_reg_write  && (wb_rd_addr  != '0) && (wb_rd_addr  == ex_q.rs1Addr);
   assign wbHit2  = wb_reg_write  && (wb_rd_addr  != '0) && (wb_rd_addr  == ex_q.rs2Addr);

   assign fwd1 = memHit1 ? mem_result : (wbHit1 ? wb_result : ex_q.rs1Data);
   assign fwd2 = memHit2 ? mem_result : (wbHit2 ? wb_result : ex_q.rs2Data);

   assign ex_valid      = ex_q.valid;
   assign ex_pc         = ex_q.pc;
   assign ex_srcA       = ex_q.srcASel ? ex_q.pc  : fwd1;
   assign ex_srcB       = ex_q.srcBSel ? ex_q.imm : fwd2;
   assign ex_store_data = fwd2;
   assign ex_alu_fun    = ex_q.aluFun;
   assign ex_rd_addr    = ex_q.rdAddr;
   assign ex_reg_write  = ex_q.regWrite;
   assign ex_mem_read   = ex_q.memRead;
   assign ex_mem_write  = ex_q.memWrite;

endmodule

// File: tb/tb_pipe_id_ex.sv
// Self-checking bench for pipe_id_ex: directed scenarios followed by random
// traffic, all compared against a behavioural model of the EX-stage instruction.
module tb_pipe_id_ex;

   logic        CLK;
   logic        RST;
   logic        stall;
   logic        flush;
   logic        id_valid;
   logic [31:0] id_pc;
   logic [31:0] id_rs1_data;
   logic [31:0] id_rs2_data;
   logic [31:0] id_imm;
   logic [4:0]  id_rs1_addr;
   logic [4:0]  id_rs2_addr;
   logic [4:0]  id_rd_addr;
   logic [3:0]  id_alu_fun;
   logic        id_srcA_sel;
   logic        id_srcB_sel;
   logic        id_reg_write;
   logic        id_mem_read;
   logic        id_mem_write;
   logic [4:0]  mem_rd_addr;
   logic        mem_reg_write;
   logic [31:0] mem_result;
   logic [4:0]  wb_rd_addr;
   logic        wb_reg_write;
   logic [31:0] wb_result;
   logic        ex_valid;
   logic [31:0] ex_pc;
   logic [31:0] ex_srcA;
   logic [31:0] ex_srcB;
   logic [3:0]  ex_alu_fun;
   logic [31:0] ex_store_data;
   logic [4:0]  ex_rd_addr;
   logic        ex_reg_write;
   logic        ex_mem_read;
   logic        ex_mem_write;
   logic        hazard_stall;

   int checkCount = 0;
   int errorCount = 0;

   // The instruction the model believes is sitting in EX.
   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] rs1Data;
      logic [31:0] rs2Data;
      logic [31:0] imm;
      logic [4:0]  rs1Addr;
      logic [4:0]  rs2Addr;
      logic [4:0]  rdAddr;
      logic [3:0]  aluFun;
      logic        srcASel;
      logic        srcBSel;
      logic        regWrite;
      logic        memRead;
      logic        memWrite;
   } exModel_t;

   exModel_t model;

   pipe_id_ex #(.XLEN(32), .REG_AW(5)) dut (
      .CLK(CLK), .RST(RST), .stall(stall), .flush(flush),
      .id_valid(id_valid), .id_pc(id_pc),
      .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
      .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
      .id_alu_fun(id_alu_fun), .id_srcA_sel(id_srcA_sel), .id_srcB_sel(id_srcB_sel),
      .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
      .mem_rd_addr(mem_rd_addr), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
      .wb_rd_addr(wb_rd_addr), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
      .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_srcA(ex_srcA), .ex_srcB(ex_srcB),
      .ex_alu_fun(ex_alu_fun), .ex_store_data(ex_store_data), .ex_rd_addr(ex_rd_addr),
      .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
      .hazard_stall(hazard_stall)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
      end
   endtask

   // Value the ALU should see for a register source, given the current forward buses.
   function automatic logic [31:0] expectFwd(input logic [4:0] addr, input logic [31:0] regData);
      if (addr == 5'd0) return regData;
      if (mem_reg_write && mem_rd_addr == addr) return mem_result;
      if (wb_reg_write && wb_rd_addr == addr) return wb_result;
      return regData;
   endfunction

   function automatic logic expectHazard();
      return model.valid && model.memRead && model.rdAddr != 5'd0 && id_valid &&
             (model.rdAddr == id_rs1_addr || model.rdAddr == id_rs2_addr);
   endfunction

   task automatic checkAll();
      logic [31:0] f1;
      logic [31:0] f2;
      f1 = expectFwd(model.rs1Addr, model.rs1Data);
      f2 = expectFwd(model.rs2Addr, model.rs2Data);
      checkOutput("ex_valid", ex_valid, model.valid);
      checkOutput("ex_pc", ex_pc, model.pc);
      checkOutput("ex_srcA", ex_srcA, model.srcASel ? model.pc : f1);
      checkOutput("ex_srcB", ex_srcB, model.srcBSel ? model.imm : f2);
      checkOutput("ex_store_data", ex_store_data, f2);
      checkOutput("ex_alu_fun", ex_alu_fun, model.aluFun);
      checkOutput("ex_rd_addr", ex_rd_addr, model.rdAddr);
      checkOutput("ex_reg_write", ex_reg_write, model.regWrite);
      checkOutput("ex_mem_read", ex_mem_read, model.memRead);
      checkOutput("ex_mem_write", ex_mem_write, model.memWrite);
      checkOutput("hazard_stall", hazard_stall, expectHazard());
   endtask

   // What EX will hold after the coming rising edge, from the current inputs.
   task automatic modelUpdate();
      exModel_t next;
      if (flush) begin
         next = '0;
      end else if (stall) begin
         next = model;
      end else if (expectHazard()) begin
         next = '0;
      end else begin
         next.valid    = id_valid;
         next.pc       = id_pc;
         next.rs1Data  = id_rs1_data;
         next.rs2Data  = id_rs2_data;
         next.imm      = id_imm;
         next.rs1Addr  = id_rs1_addr;
         next.rs2Addr  = id_rs2_addr;
         next.rdAddr   = id_rd_addr;
         next.aluFun   = id_alu_fun;
         next.srcASel  = id_srcA_sel;
         next.srcBSel  = id_srcB_sel;
         next.regWrite = id_valid && id_reg_write;
         next.memRead  = id_valid && id_mem_read;
         next.memWrite = id_valid && id_mem_write;
      end
      model = next;
   endtask

   // Inputs are set at the falling edge; this checks, predicts, and moves one cycle on.
   task automatic applyStimulus();
      #1;
      checkAll();
      modelUpdate();
      @(negedge CLK);
   endtask

   task automatic clearInputs();
      stall = 0; flush = 0; id_valid = 0;
      id_pc = 0; id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
      id_rs1_addr = 0; id_rs2_addr = 0; id_rd_addr = 0; id_alu_fun = 0;
      id_srcA_sel = 0; id_srcB_sel = 0;
      id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
      mem_rd_addr = 0; mem_reg_write = 0; mem_result = 0;
      wb_rd_addr = 0; wb_reg_write = 0; wb_result = 0;
   endtask

   // Small address range keeps forwarding and load-use collisions frequent.
   task automatic randomInputs();
      flush         = ($urandom_range(0, 7) == 0);
      stall         = ($urandom_range(0, 5) == 0);
      id_valid      = ($urandom_range(0, 3) != 0);
      id_pc         = $urandom;
      id_rs1_data   = $urandom;
      id_rs2_data   = $urandom;
      id_imm        = $urandom;
      id_rs1_addr   = 5'($urandom_range(0, 7));
      id_rs2_addr   = 5'($urandom_range(0, 7));
      id_rd_addr    = 5'($urandom_range(0, 7));
      id_alu_fun    = 4'($urandom_range(0, 15));
      id_srcA_sel   = 1'($urandom_range(0, 1));
      id_srcB_sel   = 1'($urandom_range(0, 1));
      id_reg_write  = 1'($urandom_range(0, 1));
      id_mem_read   = 1'($urandom_range(0, 1));
      id_mem_write  = 1'($urandom_range(0, 1));
      mem_rd_addr   = 5'($urandom_range(0, 7));
      mem_reg_write = 1'($urandom_range(0, 1));
      mem_result    = $urandom;
      wb_rd_addr    = 5'($urandom_range(0, 7));
      wb_reg_write  = 1'($urandom_range(0, 1));
      wb_result     = $urandom;
   endtask

   initial begin
      clearInputs();
      RST   = 1;
      model = '0;
      @(negedge CLK);
      checkAll();
      RST = 0;

      $display("[TB] basic load");
      id_valid = 1; id_rs1_addr = 1; id_rs1_data = 5; id_imm = 7; id_srcB_sel = 1;
      id_alu_fun = 4'b0000; id_rd_addr = 3; id_reg_write = 1;
      applyStimulus();
      clearInputs();
      #1;
      checkOutput("basic srcA", ex_srcA, 32'd5);
      checkOutput("basic srcB", ex_srcB, 32'd7);
      checkOutput("basic rd", ex_rd_addr, 32'd3);
      checkOutput("basic reg_write", ex_reg_write, 32'd1);
      applyStimulus();

      $display("[TB] forward priority");
      id_valid = 1; id_rs1_addr = 4; id_rs1_data = 1;
      applyStimulus();
      clearInputs();
      stall = 1;
      mem_reg_write = 1; mem_rd_addr = 4; mem_result = 32'hAAAA;
      wb_reg_write = 1;  wb_rd_addr = 4;  wb_result = 32'hBBBB;
      #1;
      checkOutput("fwd mem wins", ex_srcA, 32'hAAAA);
      applyStimulus();
      mem_reg_write = 0;
      #1;
      checkOutput("fwd wb", ex_srcA, 32'hBBBB);
      applyStimulus();
      stall = 0; id_valid = 1; id_rs1_addr = 0; id_rs1_data = 1;
      mem_reg_write = 1; mem_rd_addr = 0; wb_reg_write = 1; wb_rd_addr = 0;
      applyStimulus();
      #1;
      checkOutput("fwd x0 blocked", ex_srcA, 32'd1);
      applyStimulus();

      $display("[TB] load-use");
      clearInputs();
      id_valid = 1; id_mem_read = 1; id_reg_write = 1; id_rd_addr = 5; id_rs1_addr = 2;
      applyStimulus();
      clearInputs();
      id_valid = 1; id_rs2_addr = 5; id_rs1_addr = 6;
      #1;
      checkOutput("loaduse hazard", hazard_stall, 32'd1);
      applyStimulus();
      #1;
      checkOutput("loaduse bubble", ex_valid, 32'd0);
      checkOutput("loaduse release", hazard_stall, 32'd0);
      applyStimulus();

      $display("[TB] stall and flush");
      clearInputs();
      id_valid = 1; id_pc = 32'h100; id_rd_addr = 7; id_reg_write = 1;
      applyStimulus();
      clearInputs();
      stall = 1; id_valid = 1; id_pc = 32'h200; id_rd_addr = 9; id_reg_write = 1;
      applyStimulus();
      applyStimulus();
      #1;
      checkOutput("stall hold pc", ex_pc, 32'h100);
      checkOutput("stall hold rd", ex_rd_addr, 32'd7);
      flush = 1;
      applyStimulus();
      #1;
      checkOutput("flush valid", ex_valid, 32'd0);
      checkOutput("flush reg_write", ex_reg_write, 32'd0);
      applyStimulus();

      $display("[TB] invalid ID slot");
      clearInputs();
      id_valid = 0; id_reg_write = 1; id_mem_write = 1; id_rd_addr = 4;
      applyStimulus();
      #1;
      checkOutput("invalid valid", ex_valid, 32'd0);
      checkOutput("invalid reg_write", ex_reg_write, 32'd0);
      checkOutput("invalid mem_write", ex_mem_write, 32'd0);
      applyStimulus();

      $display("[TB] random traffic");
      for (int i = 0; i < 400; i++) begin
         randomInputs();
         applyStimulus();
      end

      $display("[TB] reset mid-stream");
      clearInputs();
      id_valid = 1; id_rs1_addr = 1; id_rs2_addr = 2; id_rd_addr = 3; id_reg_write = 1;
      id_alu_fun = 4'b0000; id_rs1_data = 32'h11; id_rs2_data = 32'h22; id_pc = 32'h40;
      applyStimulus();
      id_alu_fun = 4'b0101;
      applyStimulus();
      RST = 1;
      #1;
      model = '0;
      checkAll();
      checkOutput("reset alu_fun", ex_alu_fun, 32'd0);
      checkOutput("reset rd", ex_rd_addr, 32'd0);
      #1;
      RST = 0;
      @(negedge CLK);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
